dlx_ifetch: RTL and testbench
=============================

Name: dlx_ifetch

Overview:
- Instruction-fetch stage of the DLX pipeline; sits directly upstream of the IF/ID boundary and drives the combinational-read instruction SRAM (`sram`).
- Holds the PC, issues one read per cycle and captures each instruction word with its PC into a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Handles redirects (branch/jump taken) and halt, including flushing of already-fetched words.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; legal values 2..4.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- imem_cs  output  1  SRAM chip select; high when a fetch is issued this cycle.
- imem_oe  output  1  SRAM output enable; equals imem_cs.
- imem_we  output  1  SRAM write enable; constant 0.
- imem_addr  output  32  fetch address; always equals pc.
- imem_din  output  32  SRAM write data; constant 0.
- imem_dout  input  [0:31]  instruction word; valid combinationally in the same cycle as imem_addr.
- redirect_valid  input  1  taken branch/jump from EX.
- redirect_pc  input  32  redirect target.
- halt  input  1  suspend fetching while high.
- id_valid  output  1  buffer head valid.
- id_ready  input  1  decode accepts head this cycle.
- id_instr  output  [0:31]  head instruction, bit 0 = opcode MSB.
- id_pc  output  32  PC of head instruction.
- id_npc  output  32  id_pc + 4, used for link register (jal).

Behaviour:
- **Reset** (async, reset_n=0):
  - pc=RESET_PC; FIFO count=0; read/write pointers=0.
  - id_valid=0, id_instr=0, id_pc=0, id_npc=0.
  - imem_cs=imem_oe=0.
  - Release takes effect on the first clk edge with reset_n=1.
- **Reset mid-operation:** discards all buffered words with no partial output. The first fetch after release is from RESET_PC.
- **pop** = id_valid & id_ready.
- **can_fetch** = !redirect_valid & !halt & (count < BUF_DEPTH | pop).
  - Full-with-simultaneous-pop still fetches.
  - Full without pop stalls; pc holds.
- **imem_cs** = can_fetch, evaluated combinationally each cycle.
- **On a clk edge with can_fetch:**
  - Push {imem_dout, pc} into the FIFO.
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- **Latency:** a word fetched in cycle N is visible at id_* in cycle N+1 when the FIFO was empty. id_* are driven from the registered head entry, never combinationally from imem_dout.
- **Simultaneous push and pop:** count is unchanged; both pointers advance modulo BUF_DEPTH.
- **Redirect** (highest priority over halt, push and pop):
  - On the edge: FIFO is flushed (count=0, pointers=0) and pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - id_valid=0 in the following cycle.
  - The target word appears at id_* two cycles after redirect_valid is sampled.
  - A pop in the redirect cycle is still honoured by decode, but its buffer slot is cleared anyway.
- **Halt:** no fetch and pc holds. The FIFO continues to drain to decode. Fetching resumes the cycle halt falls.
- **id_valid / id_ready:** id_valid never drops without a pop or a redirect. id_* stay stable while id_valid=1 and id_ready=0.
- **Empty FIFO:** id_valid=0; id_instr/id_pc hold their last values and are don't-care.
- **FSM:** none beyond the count-based FULL/PARTIAL/EMPTY derivation. count width = clog2(BUF_DEPTH+1).

Decomposition:
- Shared package `dlx_pkg`:
  - INSTR_W=32, ADDR_W=32, PC_INC=4.
  - NOP encoding 32'h0000_0000.
  - Opcode constants for bench decoding: ADDI=6'b001000, JAL=6'b000011, BNEZ=6'b000101.
- One sub-module: `ifetch_buf`, a parameterised sync FIFO with flush input, storing {instr, pc}.
- dlx_ifetch contains the PC register, fetch control and SRAM interface.

Test Plan:
1. Reset, then hold id_ready=1 with `sram` attached.
   - Cycle 1 after release: id_instr=32'h2001_AAAA, id_pc=0, id_npc=4.
   - Next cycle: id_pc=4.
2. Set id_ready=0 for 4 cycles from reset.
   - FIFO fills with pc 0x0 and 0x4; imem_cs falls and pc holds at 0x8.
   - On id_ready=1, words drain in order 0x0, 0x4, 0x8 with no loss or duplication.
3. With the FIFO full, assert redirect_valid for 1 cycle with redirect_pc=32'h80.
   - Next cycle id_valid=0.
   - Following cycle id_instr=32'hF0F0_77F0, id_pc=32'h80.
   - Repeat with redirect_pc=32'h83: pc becomes 32'h80.
4. Assert halt for 3 cycles with id_ready=1.
   - imem_cs=0 and pc is frozen; buffered words still pop.
   - Fetch resumes from the frozen pc when halt falls.
5. Redirect to 32'hFFFF_FFF8 and run.
   - Fetches at 0xFFFF_FFF8, then 0xFFFF_FFFC, then 0x0.
   - id_npc of the 0xFFFF_FFFC word = 0.
6. Pulse reset_n low mid-cycle with 2 words buffered.
   - id_valid and imem_cs go 0 immediately, asynchronously.
   - After release, the first delivered id_pc=RESET_PC.

Source files
------------

// File: rtl/dlx_pkg.sv
// DLX shared types and constants.
// Fetch entry layout and buffer fill levels.
package dlx_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
  localparam logic [ADDR_W-1:0] PC_MASK = 32'hFFFF_FFFC;
  localparam logic [0:INSTR_W-1] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BNEZ = 6'b000101;

  typedef struct packed {
    logic [0:INSTR_W-1] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_ent_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_PARTIAL,
    BUF_FULL
  } buf_lvl_e;

endpackage

// File: rtl/ifetch_buf.sv
// Sync FIFO of fetched {instr, pc} entries.
// Flush clears pointers and count in one edge.
module ifetch_buf
  import dlx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  fetch_ent_t i_data,
  output fetch_ent_t o_head,
  output buf_lvl_e   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_ent_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;

  assign w_wr_nxt = (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
  assign w_rd_nxt = (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
  assign o_head = r_mem[r_rd];

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= w_wr_nxt;
      end
      if (i_pop) r_rd <= w_rd_nxt;
      if (i_push && !i_pop) r_cnt <= r_cnt + CW'(1);
      else if (!i_push && i_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Fill level decoded from occupancy.
  always_comb begin
    o_level = BUF_PARTIAL;
    unique case (1'b1)
      (r_cnt == '0):         o_level = BUF_EMPTY;
      (r_cnt == CW'(DEPTH)): o_level = BUF_FULL;
      default:               o_level = BUF_PARTIAL;
    endcase
  end

endmodule

// File: rtl/dlx_ifetch.sv
// DLX instruction fetch stage: PC, SRAM read,
// fetch buffer and decode handshake.
module dlx_ifetch
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_cs,
  output logic        imem_oe,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  input  logic [0:31] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [0:31] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc
);

  logic [ADDR_W-1:0] r_pc;
  logic              w_pop;
  logic              w_fetch;
  buf_lvl_e          w_level;
  fetch_ent_t        w_head;
  fetch_ent_t        w_push_ent;

  assign id_valid = (w_level != BUF_EMPTY);
  assign w_pop = id_valid & id_ready;
  // Reset gates the fetch so the SRAM is idle while held.
  assign w_fetch = reset_n & ~redirect_valid & ~halt &
                   ((w_level != BUF_FULL) | w_pop);

  assign imem_cs = w_fetch;
  assign imem_oe = w_fetch;
  assign imem_we = 1'b0;
  assign imem_din = '0;
  assign imem_addr = r_pc;

  assign w_push_ent.instr = imem_dout;
  assign w_push_ent.pc = r_pc;

  assign id_instr = w_head.instr;
  assign id_pc = w_head.pc;
  assign id_npc = id_valid ? w_head.pc + PC_INC : '0;

  // PC: redirect target (word aligned) or sequential advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= redirect_pc & PC_MASK;
    else if (w_fetch) r_pc <= r_pc + PC_INC;
  end

  ifetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .i_flush(redirect_valid),
    .i_push (w_fetch),
    .i_pop  (w_pop),
    .i_data (w_push_ent),
    .o_head (w_head),
    .o_level(w_level)
  );

endmodule

// File: tb/tb_dlx_ifetch.sv
// Bench for dlx_ifetch: SRAM model, queue of
// expected fetch entries, one task per scenario.
module tb_dlx_ifetch;
  import dlx_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_cs, imem_oe, imem_we;
  logic [31:0] imem_addr, imem_din;
  logic [0:31] imem_dout;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [0:31] id_instr;
  logic [31:0] id_pc, id_npc;

  int n_pass = 0;
  int n_total = 0;

  fetch_ent_t  q[$];
  logic [31:0] m_pc = RST_PC;

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_AAAA;
      32'h0000_0080: return 32'hF0F0_77F0;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_dout = sram_word(imem_addr);

  dlx_ifetch #(
    .RESET_PC (RST_PC),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_cs       (imem_cs),
    .imem_oe       (imem_oe),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_din      (imem_din),
    .imem_dout     (imem_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_npc        (id_npc)
  );

  function automatic logic exp_cs();
    return reset_n && !redirect_valid && !halt &&
           (q.size() < 2 || (q.size() > 0 && id_ready));
  endfunction

  // Reference fetch model: queue of words decode should see.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_pc <= RST_PC;
    end else if (redirect_valid) begin
      q.delete();
      m_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (q.size() > 0 && id_ready) begin
      void'(q.pop_front());
      if (!halt) begin
        q.push_back('{instr: sram_word(m_pc), pc: m_pc});
        m_pc <= m_pc + 32'd4;
      end
    end else if (!halt && q.size() < 2) begin
      q.push_back('{instr: sram_word(m_pc), pc: m_pc});
      m_pc <= m_pc + 32'd4;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (id_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", id_valid);
    else n_pass++;
    n_total++;
    if (id_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", id_instr);
    else n_pass++;
    n_total++;
    if (id_pc !== 32'h0 || id_npc !== 32'h0)
      $display("FAIL rst_pc got %h/%h want 0/0", id_pc, id_npc);
    else n_pass++;
    n_total++;
    if (imem_cs !== 1'b0 || imem_oe !== 1'b0)
      $display("FAIL rst_cs got %b/%b want 0/0", imem_cs, imem_oe);
    else n_pass++;
    n_total++;
    if (imem_we !== 1'b0 || imem_din !== 32'h0)
      $display("FAIL rst_we got %b/%h want 0/0", imem_we, imem_din);
    else n_pass++;
    n_total++;
    if (imem_addr !== RST_PC) $display("FAIL rst_addr got %h want %h", imem_addr, RST_PC);
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    #1;
    n_total++;
    if (imem_cs !== 1'b1) $display("FAIL s_cs0 got %b want 1", imem_cs);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (id_valid !== 1'b1 || id_instr !== 32'h2001_AAAA)
      $display("FAIL s_first got %b/%h want 1/2001aaaa", id_valid, id_instr);
    else n_pass++;
    n_total++;
    if (id_pc !== 32'h0 || id_npc !== 32'h4)
      $display("FAIL s_first_pc got %h/%h want 0/4", id_pc, id_npc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (id_pc !== 32'h4) $display("FAIL s_second_pc got %h want 4", id_pc);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (q.size() == 0 || id_valid !== 1'b1 ||
          id_pc !== q[0].pc || id_instr !== q[0].instr)
        $display("FAIL s_stream%0d got %h/%h want %h/%h",
                 i, id_pc, id_instr, q[0].pc, q[0].instr);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want [3] = '{32'h0, 32'h4, 32'h8};
    reset_n = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (imem_cs !== 1'b0 || imem_addr !== 32'h8 || id_pc !== 32'h0)
        $display("FAIL bp_stall%0d got %b/%h/%h want 0/8/0",
                 i, imem_cs, imem_addr, id_pc);
      else n_pass++;
    end
    id_ready = 1'b1;
    #1;
    n_total++;
    if (imem_cs !== exp_cs()) $display("FAIL bp_fullpop_cs got %b want %b", imem_cs, exp_cs());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (id_valid !== 1'b1 || id_pc !== want[i] || id_instr !== sram_word(want[i]))
        $display("FAIL bp_drain%0d got %h/%h want %h/%h",
                 i, id_pc, id_instr, want[i], sram_word(want[i]));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    #1;
    n_total++;
    if (imem_cs !== 1'b0) $display("FAIL rd_cs got %b want 0", imem_cs);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h80 || imem_cs !== 1'b1)
      $display("FAIL rd_flush got %b/%h/%b want 0/80/1", id_valid, imem_addr, imem_cs);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (id_valid !== 1'b1 || id_instr !== 32'hF0F0_77F0)
      $display("FAIL rd_target got %b/%h want 1/f0f077f0", id_valid, id_instr);
    else n_pass++;
    n_total++;
    if (id_pc !== 32'h80 || id_npc !== 32'h84)
      $display("FAIL rd_target_pc got %h/%h want 80/84", id_pc, id_npc);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h83;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (imem_addr !== 32'h80 || id_valid !== 1'b0)
      $display("FAIL rd_align got %h/%b want 80/0", imem_addr, id_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (id_pc !== 32'h80 || imem_addr !== 32'h88 || imem_cs !== 1'b0)
      $display("FAIL rd_refill got %h/%h/%b want 80/88/0", id_pc, imem_addr, imem_cs);
    else n_pass++;
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    frozen = m_pc;
    halt = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (imem_cs !== 1'b0 || imem_addr !== frozen)
        $display("FAIL h_frozen%0d got %b/%h want 0/%h", i, imem_cs, imem_addr, frozen);
      else n_pass++;
      n_total++;
      if (id_valid !== (q.size() > 0) || (q.size() > 0 && id_pc !== q[0].pc))
        $display("FAIL h_drain%0d got %b/%h want %b/%h",
                 i, id_valid, id_pc, q.size() > 0, q[0].pc);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (id_valid !== 1'b0) $display("FAIL h_empty got %b want 0", id_valid);
    else n_pass++;
    halt = 1'b0;
    #1;
    n_total++;
    if (imem_cs !== 1'b1 || imem_addr !== frozen)
      $display("FAIL h_resume got %b/%h want 1/%h", imem_cs, imem_addr, frozen);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (id_valid !== 1'b1 || id_pc !== frozen)
      $display("FAIL h_first got %b/%h want 1/%h", id_valid, id_pc, frozen);
    else n_pass++;
  endtask

  task automatic test_wrap();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (imem_addr !== 32'hFFFF_FFF8) $display("FAIL w_addr0 got %h want fffffff8", imem_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (imem_addr !== 32'hFFFF_FFFC || id_pc !== 32'hFFFF_FFF8)
      $display("FAIL w_addr1 got %h/%h want fffffffc/fffffff8", imem_addr, id_pc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_npc !== 32'h0)
      $display("FAIL w_wrap got %h/%h/%h want 0/fffffffc/0", imem_addr, id_pc, id_npc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (id_pc !== 32'h0 || id_instr !== 32'h2001_AAAA)
      $display("FAIL w_zero got %h/%h want 0/2001aaaa", id_pc, id_instr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (id_valid !== 1'b1) $display("FAIL rm_buffered got %b want 1", id_valid);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (id_valid !== 1'b0 || imem_cs !== 1'b0 || imem_addr !== RST_PC)
      $display("FAIL rm_async got %b/%b/%h want 0/0/%h", id_valid, imem_cs, imem_addr, RST_PC);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (id_valid !== 1'b1 || id_pc !== RST_PC || id_instr !== 32'h2001_AAAA)
      $display("FAIL rm_first got %b/%h/%h want 1/%h/2001aaaa",
               id_valid, id_pc, id_instr, RST_PC);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
